// File: rtl/kernel_map_node_pipe.sv
// kernel_map_node_pipe: a leaf map node that combines NIN input streams with one
// integer op and delays the result through LAT pipeline stages.
// The whole pipe stalls while the downstream is not ready. A counter tracks how
// many results the downstream has taken.
module kernel_map_node_pipe #(
  parameter int STREAMW = 34,
  parameter int NIN     = 2,
  parameter int LAT     = 3,
  parameter int OPMODE  = 1,
  parameter int CNTW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NIN-1:0]           ivalid_in,
  input  logic [NIN*STREAMW-1:0]   in_data,
  output logic                     iready,
  output logic                     ovalid,
  output logic [STREAMW-1:0]       out1,
  input  logic                     oready,
  output logic [CNTW-1:0]          ocount
);

  // Reject parameter sets the datapath cannot implement.
  if (NIN < 1 || NIN > 4 || LAT < 1 || OPMODE < 0 || OPMODE > 3 ||
      (OPMODE == 2 && NIN < 2)) begin : g_param_check
    $error("kernel_map_node_pipe: illegal parameter combination");
  end

  logic [STREAMW-1:0] in_word [NIN];
  logic [STREAMW-1:0] op_result;
  logic               ivalid;
  logic               adv;

  logic [STREAMW-1:0] stage_data_reg [LAT];
  logic [LAT-1:0]     stage_valid_reg;
  logic [CNTW-1:0]    ocount_reg;

  // Split the packed input bus into one word per stream.
  for (genvar gi = 0; gi < NIN; gi++) begin : g_unpack
    assign in_word[gi] = in_data[gi*STREAMW +: STREAMW];
  end

  // A set counts only when every stream is valid. The node itself never stalls,
  // so it is ready exactly when the pipe can advance.
  assign ivalid = &ivalid_in;
  assign adv    = oready;
  assign iready = oready;

  // Combinational op on the current input set. All arithmetic wraps at 2^STREAMW.
  if (OPMODE == 1) begin : g_op_add
    // Sum all inputs.
    always_comb begin
      op_result = '0;
      for (int k = 0; k < NIN; k++) begin
        op_result = op_result + in_word[k];
      end
    end
  end else if (OPMODE == 2 && NIN >= 2) begin : g_op_sub
    // Subtract input 2 from input 1.
    always_comb begin
      op_result = in_word[0] - in_word[1];
    end
  end else if (OPMODE == 3) begin : g_op_max
    // Unsigned maximum over all inputs.
    always_comb begin
      op_result = in_word[0];
      for (int k = 1; k < NIN; k++) begin
        if (in_word[k] > op_result) begin
          op_result = in_word[k];
        end
      end
    end
  end else begin : g_op_pass
    // Pass input 1 through unchanged.
    always_comb begin
      op_result = in_word[0];
    end
  end

  // Pipeline stages. Stage 0 captures the op result (or a zeroed bubble).
  // Later stages are pure delay. Every stage holds while adv is low.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // Load a new result or a bubble whenever the pipe advances.
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_data_reg[0]  <= '0;
          stage_valid_reg[0] <= 1'b0;
        end else if (adv) begin
          stage_data_reg[0]  <= ivalid ? op_result : '0;
          stage_valid_reg[0] <= ivalid;
        end
      end
    end else begin : g_delay
      // Shift the previous stage forward whenever the pipe advances.
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_data_reg[gi]  <= '0;
          stage_valid_reg[gi] <= 1'b0;
        end else if (adv) begin
          stage_data_reg[gi]  <= stage_data_reg[gi-1];
          stage_valid_reg[gi] <= stage_valid_reg[gi-1];
        end
      end
    end
  end

  assign ovalid = stage_valid_reg[LAT-1];
  assign out1   = stage_data_reg[LAT-1];

  // Count results handed to the downstream. The counter wraps at 2^CNTW.
  always_ff @(posedge clk) begin
    if (rst) begin
      ocount_reg <= '0;
    end else if (ovalid && oready) begin
      ocount_reg <= ocount_reg + CNTW'(1);
    end
  end

  assign ocount = ocount_reg;

endmodule

// File: tb/tb_kernel_map_node_pipe.sv
// Testbench for kernel_map_node_pipe.
// Three instances are driven side by side: add with 2 inputs, sub with 2 inputs,
// and max with 4 inputs.
module tb_kernel_map_node_pipe;

  localparam int SW  = 34;
  localparam int LAT = 3;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst;
  logic oready;
  logic [3:0]    vin;
  logic [SW-1:0] a_in, b_in, c_in, d_in;
  logic [1:0]    v2;
  logic [2*SW-1:0] d2;
  logic [4*SW-1:0] d4;

  assign v2 = vin[1:0];
  assign d2 = {b_in, a_in};
  assign d4 = {d_in, c_in, b_in, a_in};

  logic          rdy_add, rdy_sub, rdy_max;
  logic          ov_add, ov_sub, ov_max;
  logic [SW-1:0] out_add, out_sub, out_max;
  logic [CW-1:0] cnt_add, cnt_sub, cnt_max;

  kernel_map_node_pipe #(.STREAMW(SW), .NIN(2), .LAT(LAT), .OPMODE(1), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .ivalid_in(v2), .in_data(d2), .iready(rdy_add),
    .ovalid(ov_add), .out1(out_add), .oready(oready), .ocount(cnt_add));

  kernel_map_node_pipe #(.STREAMW(SW), .NIN(2), .LAT(LAT), .OPMODE(2), .CNTW(CW)) dut_sub (
    .clk(clk), .rst(rst), .ivalid_in(v2), .in_data(d2), .iready(rdy_sub),
    .ovalid(ov_sub), .out1(out_sub), .oready(oready), .ocount(cnt_sub));

  kernel_map_node_pipe #(.STREAMW(SW), .NIN(4), .LAT(LAT), .OPMODE(3), .CNTW(CW)) dut_max (
    .clk(clk), .rst(rst), .ivalid_in(vin), .in_data(d4), .iready(rdy_max),
    .ovalid(ov_max), .out1(out_max), .oready(oready), .ocount(cnt_max));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [SW-1:0] in1, in2, in3, in4;
    logic [SW-1:0] exp_add, exp_sub, exp_max;
  } vec_t;
  vec_t tbl [7];

  // Scoreboard state for the random phase.
  logic [SW-1:0] q0 [$];
  logic [SW-1:0] q1 [$];
  logic [SW-1:0] q2 [$];
  logic [CW-1:0] sb_cnt [3];
  logic          hold_flag;
  logic [SW-1:0] held_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [SW-1:0] c, input logic [SW-1:0] d, input logic [3:0] v);
    a_in = a; b_in = b; c_in = c; d_in = d; vin = v;
  endtask

  task automatic do_reset();
    set_in('0, '0, '0, '0, 4'h0);
    oready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) sb_cnt[i] = '0;
    hold_flag = 1'b0;
  endtask

  // Reference ops, computed directly from the arithmetic rules.
  function automatic logic [SW-1:0] ref_max(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic [SW-1:0] c, input logic [SW-1:0] d);
    logic [SW-1:0] vals [4];
    logic [SW-1:0] m;
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    m = '0;
    foreach (vals[i]) if (vals[i] > m) m = vals[i];
    return m;
  endfunction

  function automatic logic [SW-1:0] rnd34();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return r[SW-1:0];
    endcase
  endfunction

  task automatic score_one(input int idx, input logic ov, input logic [SW-1:0] ob,
                           input logic [CW-1:0] oc);
    logic [SW-1:0] expv;
    int sz;
    chk($sformatf("ocount_inst%0d", idx), oc, sb_cnt[idx]);
    if (ov && oready) begin
      case (idx)
        0:       sz = q0.size();
        1:       sz = q1.size();
        default: sz = q2.size();
      endcase
      if (sz == 0) begin
        chk($sformatf("spurious_item_inst%0d", idx), 64'(ob), 64'h1_0000_0000_0);
      end else begin
        case (idx)
          0:       expv = q0.pop_front();
          1:       expv = q1.pop_front();
          default: expv = q2.pop_front();
        endcase
        chk($sformatf("stream_out1_inst%0d", idx), ob, expv);
      end
      sb_cnt[idx] = sb_cnt[idx] + 1;
    end
  endtask

  // Sample at the falling edge and account for the transfers and accepts that
  // happen at the next rising edge.
  task automatic score_cycle();
    @(negedge clk);
    if (hold_flag) begin
      chk("stall_hold_ovalid", ov_add, 1);
      chk("stall_hold_out1", out_add, held_val);
    end
    hold_flag = ov_add && !oready;
    held_val  = out_add;
    score_one(0, ov_add, out_add, cnt_add);
    score_one(1, ov_sub, out_sub, cnt_sub);
    score_one(2, ov_max, out_max, cnt_max);
    if ((&v2) && oready) begin
      q0.push_back(a_in + b_in);
      q1.push_back(a_in - b_in);
    end
    if ((&vin) && oready) q2.push_back(ref_max(a_in, b_in, c_in, d_in));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] got [$];
    int next;

    tbl[0] = '{34'd5, 34'd7, 34'd0, 34'd0, 34'd12, 34'h3_FFFF_FFFE, 34'd7};
    tbl[1] = '{34'h3_FFFF_FFFF, 34'd1, 34'd0, 34'd0, 34'd0, 34'h3_FFFF_FFFE, 34'h3_FFFF_FFFF};
    tbl[2] = '{34'd3, 34'd5, 34'd1, 34'd4, 34'd8, 34'h3_FFFF_FFFE, 34'd5};
    tbl[3] = '{34'd9, 34'd2, 34'h2_0000_0000, 34'd7, 34'd11, 34'd7, 34'h2_0000_0000};
    tbl[4] = '{34'd100, 34'd58, 34'd30, 34'd99, 34'd158, 34'd42, 34'd100};
    tbl[5] = '{34'h1_2345_6789, 34'h0_1111_1111, 34'd2, 34'h3_FFFF_FFF0,
               34'h1_3456_789A, 34'h1_1234_5678, 34'h3_FFFF_FFF0};
    tbl[6] = '{34'd0, 34'd0, 34'd0, 34'd0, 34'd0, 34'd0, 34'd0};

    // Reset state
    do_reset();
    chk("reset_ovalid", ov_add, 0);
    chk("reset_out1", out_add, 0);
    chk("reset_ocount", cnt_add, 0);
    chk("reset_ovalid_max", ov_max, 0);
    chk("iready_follows_oready", rdy_add, 1);

    // Table vectors: exact latency, op results, counter update
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].in1, tbl[i].in2, tbl[i].in3, tbl[i].in4, 4'hF);
      step();
      set_in('0, '0, '0, '0, 4'h0);
      for (int k = 1; k < LAT; k++) begin
        chk($sformatf("early_ovalid_add_v%0d", i), ov_add, 0);
        chk($sformatf("early_ovalid_max_v%0d", i), ov_max, 0);
        step();
      end
      chk($sformatf("lat_ovalid_add_v%0d", i), ov_add, 1);
      chk($sformatf("lat_ovalid_max_v%0d", i), ov_max, 1);
      chk($sformatf("add_out1_v%0d", i), out_add, tbl[i].exp_add);
      chk($sformatf("sub_out1_v%0d", i), out_sub, tbl[i].exp_sub);
      chk($sformatf("max_out1_v%0d", i), out_max, tbl[i].exp_max);
      step();
      chk($sformatf("ocount_add_v%0d", i), cnt_add, i + 1);
      chk($sformatf("ocount_max_v%0d", i), cnt_max, i + 1);
      chk($sformatf("bubble_ovalid_v%0d", i), ov_add, 0);
    end

    // Partial valid sets are never inputs
    do_reset();
    for (int i = 0; i < 5 + LAT; i++) begin
      case (i % 3)
        0:       set_in(34'd1, 34'd2, 34'd3, 34'd4, 4'b0001);
        1:       set_in(34'd5, 34'd6, 34'd7, 34'd8, 4'b1110);
        default: set_in(34'd9, 34'd9, 34'd9, 34'd9, 4'b0101);
      endcase
      if (i >= 5) set_in('0, '0, '0, '0, 4'h0);
      step();
      chk("partial_ovalid_add", ov_add, 0);
      chk("partial_ovalid_max", ov_max, 0);
    end
    chk("partial_ocount", cnt_add, 0);

    // Back-pressure mid-stream: items 1..6, two stall cycles
    do_reset();
    next = 1;
    got.delete();
    hold_flag = 1'b0;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      oready = !(c == 3 || c == 4);
      if (next <= 6) set_in(SW'(next), '0, '0, '0, 4'b0011);
      else set_in('0, '0, '0, '0, 4'h0);
      @(negedge clk);
      chk("bp_iready", rdy_add, oready);
      if (hold_flag) begin
        chk("bp_hold_ovalid", ov_add, 1);
        chk("bp_hold_out1", out_add, held_val);
      end
      hold_flag = ov_add && !oready;
      held_val  = out_add;
      if (ov_add && oready) got.push_back(out_add);
      if (oready && next <= 6) next++;
      step();
    end
    chk("bp_item_count", got.size(), 6);
    foreach (got[k]) chk($sformatf("bp_item%0d", k), got[k], k + 1);
    chk("bp_ocount", cnt_add, 6);
    oready = 1'b1;

    // Reset while items are in flight
    do_reset();
    set_in(34'd1, 34'd1, 34'd1, 34'd1, 4'hF);
    step();
    set_in('0, '0, '0, '0, 4'h0);
    for (int k = 0; k < LAT + 1; k++) step();
    chk("pre_rst_ocount", cnt_add, 1);
    set_in(34'd11, 34'd22, 34'd1, 34'd1, 4'hF);
    step();
    set_in(34'd33, 34'd44, 34'd1, 34'd1, 4'hF);
    step();
    set_in('0, '0, '0, '0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ovalid", ov_add, 0);
    chk("midrst_out1", out_add, 0);
    chk("midrst_ocount", cnt_add, 0);
    chk("midrst_ocount_max", cnt_max, 0);
    for (int k = 0; k < LAT + 3; k++) begin
      step();
      chk("midrst_no_stale_add", ov_add, 0);
      chk("midrst_no_stale_max", ov_max, 0);
    end

    // Random stream against the scoreboard
    do_reset();
    for (int c = 0; c < 800; c++) begin
      set_in(rnd34(), rnd34(), rnd34(), rnd34(),
             ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom()));
      oready = ($urandom_range(0, 3) != 0);
      score_cycle();
    end
    set_in('0, '0, '0, '0, 4'h0);
    oready = 1'b1;
    for (int c = 0; c < 2 * LAT + 2; c++) score_cycle();
    chk("drain_q_add", q0.size(), 0);
    chk("drain_q_sub", q1.size(), 0);
    chk("drain_q_max", q2.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
